// File: rtl/cpe_pkg.sv
// ----------------------------------------------------------------------------
// cpe_pkg
// Shared definitions for the CPE weight-loader slice.
//   CPE_WEIGHT_WIDTH : width of one compensation weight
//   CPE_DRAIN_CYCLES : cycles spent after the last read (read latency + out reg)
//   cpe_wl_state_e   : loader FSM encoding (IDLE=0, FETCH=1, DRAIN=2, DONE=3)
// ----------------------------------------------------------------------------
package cpe_pkg;

    localparam int unsigned CPE_WEIGHT_WIDTH = 4;
    localparam int unsigned CPE_DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } cpe_wl_state_e;

endpackage

// File: rtl/cpe_weight_loader_if.sv
// ----------------------------------------------------------------------------
// cpe_weight_loader_if
// Read bus between the weight loader and Compensation_Memory.
//   mem_rd_en   : read strobe (loader -> memory)
//   mem_addr    : read address (loader -> memory)
//   mem_rd_data : read data, valid one cycle after mem_rd_en (memory -> loader)
// Modports: master = loader side, slave = memory side.
// ----------------------------------------------------------------------------
interface cpe_weight_loader_if #(
    parameter int unsigned ADDR_WIDTH = 6
);

    logic                                  mem_rd_en;
    logic [ADDR_WIDTH-1:0]                 mem_addr;
    logic [cpe_pkg::CPE_WEIGHT_WIDTH-1:0]  mem_rd_data;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data
    );

endinterface

// File: rtl/cpe_wl_addr_gen.sv
// ----------------------------------------------------------------------------
// cpe_wl_addr_gen
// Captured base address and descending row counter for one column load.
//   clk, rst_n : clock, async active-low reset
//   load_i     : capture base_addr_i and preset the counter to ARRAY_SIZE-1
//   dec_i      : step the counter down by one (held at zero once reached)
//   base_addr_i: address of the row-0 weight
//   addr_o     : base + count, modulo 2^ADDR_WIDTH
//   last_o     : counter is at zero (row-0 read)
// ----------------------------------------------------------------------------
module cpe_wl_addr_gen #(
    parameter int unsigned ARRAY_SIZE = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  dec_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam int unsigned CntW = (ARRAY_SIZE > 2) ? $clog2(ARRAY_SIZE) : 1;

    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    always_comb begin
        base_d = base_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            base_d = base_addr_i;
            cnt_d  = CntW'(ARRAY_SIZE - 1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            cnt_q  <= cnt_d;
        end
    end

    // Natural truncation of the sum gives the wrap-around address.
    assign addr_o = base_q + ADDR_WIDTH'(cnt_q);
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/cpe_weight_loader.sv
// ----------------------------------------------------------------------------
// cpe_weight_loader
// Fetches ARRAY_SIZE compensation weights from Compensation_Memory in
// descending address order and shifts them into one CPE column, so that row k
// ends up holding mem[base_addr + k].
//   clk, rst_n                    : clock, async active-low reset
//   start                         : load request, honoured only in IDLE
//   abort                         : cancel an in-flight load (FETCH/DRAIN)
//   base_addr                     : row-0 address, captured on accept
//   mem                           : memory read bus (master side)
//   Compensation_Weight           : registered weight to CPE row 0
//   Compensation_Weight_out_valid : column shift enable
//   busy                          : high in FETCH and DRAIN
//   done                          : one-cycle completion pulse
//   load_count                    : completed-load counter (CPE_WL_PERF_EN only)
// Optional feature macro: CPE_WL_PERF_EN.
// ----------------------------------------------------------------------------
module cpe_weight_loader
    import cpe_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    cpe_weight_loader_if.master         mem,
    output logic [CPE_WEIGHT_WIDTH-1:0] Compensation_Weight,
    output logic                        Compensation_Weight_out_valid,
    output logic                        busy,
    output logic                        done
`ifdef CPE_WL_PERF_EN
    ,
    output logic [15:0]                 load_count
`endif
);

    cpe_wl_state_e              state_q, state_d;
    logic [1:0]                 drain_q, drain_d;
    logic                       rd_en_d1_q, rd_en_d1_d;
    logic                       valid_q, valid_d;
    logic [CPE_WEIGHT_WIDTH-1:0] weight_q, weight_d;

    logic                  accept;
    logic                  kill;
    logic                  fetch;
    logic                  last;
    logic [ADDR_WIDTH-1:0] addr_sum;

    // abort beats a simultaneous start in IDLE.
    assign accept = (state_q == StIdle) && start && !abort;
    assign kill   = abort && ((state_q == StFetch) || (state_q == StDrain));
    assign fetch  = (state_q == StFetch);

    cpe_wl_addr_gen #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .dec_i       (fetch),
        .base_addr_i (base_addr),
        .addr_o      (addr_sum),
        .last_o      (last)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            StIdle: begin
                if (accept) state_d = StFetch;
            end
            StFetch: begin
                if (kill) begin
                    state_d = StIdle;
                end else if (last) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            StDrain: begin
                if (kill) begin
                    state_d = StIdle;
                    drain_d = '0;
                end else if (drain_q == 2'(CPE_DRAIN_CYCLES - 1)) begin
                    state_d = StDone;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Valid pipeline: rd_en -> rd_en_d1 (data returns) -> registered output.
    // An abort clears both stages at the next edge so no partial shift follows.
    always_comb begin
        rd_en_d1_d = kill ? 1'b0 : fetch;
        valid_d    = rd_en_d1_q && !kill;
        weight_d   = valid_d ? mem.mem_rd_data : weight_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            drain_q    <= '0;
            rd_en_d1_q <= 1'b0;
            valid_q    <= 1'b0;
            weight_q   <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            rd_en_d1_q <= rd_en_d1_d;
            valid_q    <= valid_d;
            weight_q   <= weight_d;
        end
    end

    assign mem.mem_rd_en                 = fetch;
    assign mem.mem_addr                  = fetch ? addr_sum : '0;
    assign Compensation_Weight           = weight_q;
    assign Compensation_Weight_out_valid = valid_q;
    assign busy                          = (state_q == StFetch) || (state_q == StDrain);
    assign done                          = (state_q == StDone);

`ifdef CPE_WL_PERF_EN
    logic [15:0] load_count_q, load_count_d;

    // Only DONE is counted, so aborted loads never reach it.
    always_comb begin
        load_count_d = load_count_q;
        if (done) load_count_d = load_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_count_q <= '0;
        end else begin
            load_count_q <= load_count_d;
        end
    end

    assign load_count = load_count_q;
`endif

endmodule

// File: tb/tb_cpe_weight_loader.sv
// ----------------------------------------------------------------------------
// tb_cpe_weight_loader
// Directed bench for cpe_weight_loader with ARRAY_SIZE=4, ADDR_WIDTH=6.
// A per-cycle table describes the basic load; short sequences cover wrap,
// abort, held start, start+abort, abort in DONE and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_cpe_weight_loader;
    import cpe_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [3:0]    weight;
    logic          valid;
    logic          busy;
    logic          done;
`ifdef CPE_WL_PERF_EN
    logic [15:0]   load_count;
`endif

    cpe_weight_loader_if #(.ADDR_WIDTH(AW)) mem_if ();

    cpe_weight_loader #(
        .ARRAY_SIZE (N),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk                           (clk),
        .rst_n                         (rst_n),
        .start                         (start),
        .abort                         (abort),
        .base_addr                     (base_addr),
        .mem                           (mem_if),
        .Compensation_Weight           (weight),
        .Compensation_Weight_out_valid (valid),
        .busy                          (busy),
        .done                          (done)
`ifdef CPE_WL_PERF_EN
        ,
        .load_count                    (load_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency.
    logic [3:0] mem [64];
    always @(posedge clk) begin
        if (mem_if.mem_rd_en) mem_if.mem_rd_data <= mem[mem_if.mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rd_en;
        logic [5:0] addr;
        logic       valid;
        logic       chk_w;
        logic [3:0] w;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [8];

    task automatic check_vec(input string tag, input int c, input vec_t v);
        string p;
        p = $sformatf("%s c%0d", tag, c);
        chk({p, " rd_en"}, 32'(mem_if.mem_rd_en), 32'(v.rd_en));
        chk({p, " addr"},  32'(mem_if.mem_addr),  32'(v.addr));
        chk({p, " valid"}, 32'(valid),            32'(v.valid));
        if (v.chk_w) chk({p, " weight"}, 32'(weight), 32'(v.w));
        chk({p, " busy"},  32'(busy),             32'(v.busy));
        chk({p, " done"},  32'(done),             32'(v.done));
    endtask

    // Issue one basic load at base 0x10; sample each cycle at the falling edge.
    // With hold set, start stays high through cycle 8 (caller drops it).
    task automatic run_basic(input string tag, input bit hold);
        @(negedge clk);
        base_addr = 6'h10;
        start     = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            check_vec(tag, c + 1, tbl[c]);
        end
    endtask

    task automatic do_abort();
        int  dones;
        @(negedge clk);
        base_addr = 6'h10;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort c3 rd_en", 32'(mem_if.mem_rd_en), 32'd0);
        chk("abort c3 busy",  32'(busy),             32'd0);
        chk("abort c3 valid", 32'(valid),            32'd0);
        dones = 0;
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            if (done || valid || busy) dones++;
        end
        chk("abort no done/valid/busy after", 32'(dones), 32'd0);
    endtask

    initial begin
        logic [5:0] wa [4];
        for (int a = 0; a < 64; a++) mem[a] = 4'((a * 7 + 3) % 16);
        for (int k = 0; k < 4; k++) mem[16 + k] = 4'(k + 1);

        //          rd   addr   vld  cw    w     busy  done
        tbl[0] = '{1'b1, 6'h13, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 6'h12, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 6'h11, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 6'h10, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 6'h00, 1'b1, 1'b1, 4'h2, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 6'h00, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 6'h00, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 6'h00, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0};

        // Reset state.
        #1;
        chk("reset rd_en",  32'(mem_if.mem_rd_en), 32'd0);
        chk("reset addr",   32'(mem_if.mem_addr),  32'd0);
        chk("reset weight", 32'(weight),           32'd0);
        chk("reset valid",  32'(valid),            32'd0);
        chk("reset busy",   32'(busy),             32'd0);
        chk("reset done",   32'(done),             32'd0);
`ifdef CPE_WL_PERF_EN
        chk("reset load_count", 32'(load_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_basic("basic", 1'b0);

        // Address wrap.
        wa[0] = 6'h01; wa[1] = 6'h00; wa[2] = 6'h3F; wa[3] = 6'h3E;
        @(negedge clk);
        base_addr = 6'h3E;
        start     = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c <= 4) chk($sformatf("wrap c%0d addr", c), 32'(mem_if.mem_addr), 32'(wa[c - 1]));
            if (c >= 3 && c <= 6) begin
                chk($sformatf("wrap c%0d valid", c), 32'(valid), 32'd1);
                chk($sformatf("wrap c%0d weight", c), 32'(weight), 32'(mem[wa[c - 3]]));
            end
            if (c == 7) chk("wrap c7 done", 32'(done), 32'd1);
        end

        // Abort in cycle 2, then a fresh load must be accepted.
        do_abort();
        run_basic("after_abort", 1'b0);

        // start held high: one load, next accept on cycle 8.
        run_basic("held", 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("held c9 rd_en", 32'(mem_if.mem_rd_en), 32'd1);
        chk("held c9 addr",  32'(mem_if.mem_addr),  32'h13);
        repeat (5) @(negedge clk);
        chk("held c14 done", 32'(done), 32'd0);
        @(negedge clk);
        chk("held c15 done", 32'(done), 32'd1);
        @(negedge clk);
        chk("held c16 busy", 32'(busy), 32'd0);

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort busy",  32'(busy),             32'd0);
        chk("start+abort rd_en", 32'(mem_if.mem_rd_en), 32'd0);

        // abort during DONE has no effect.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        chk("abort_in_done done", 32'(done), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_done idle busy", 32'(busy), 32'd0);
        chk("abort_in_done idle done", 32'(done), 32'd0);

        // Asynchronous reset in cycle 4.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midreset rd_en",  32'(mem_if.mem_rd_en), 32'd0);
        chk("midreset addr",   32'(mem_if.mem_addr),  32'd0);
        chk("midreset weight", 32'(weight),           32'd0);
        chk("midreset valid",  32'(valid),            32'd0);
        chk("midreset busy",   32'(busy),             32'd0);
        chk("midreset done",   32'(done),             32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_basic("post_reset", 1'b0);

`ifdef CPE_WL_PERF_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_basic("perf1", 1'b0);
        run_basic("perf2", 1'b0);
        do_abort();
        run_basic("perf3", 1'b0);
        chk("perf load_count", 32'(load_count), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
